// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with busy-bit scoreboard
//
// Purpose: NRD combinational read ports, NWR prioritised write ports (higher
// index wins), optional same-cycle write-to-read bypass, and one busy bit per
// register tracking pending writebacks. Register 0 reads as zero, ignores
// writes and is never marked busy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_idx/rd_data    read indices and read data, port p at [p*AW] / [p*XLEN]
//   rd_busy           pending-write flag seen by each read port
//   wr_en/idx/data    write ports
//   iss_en, iss_idx   mark a destination register busy at issue
//   flush             clear every busy bit
//   busy_vec          registered busy bits, bit r = register r

module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_idx,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Per-register write resolution: scanning ports in ascending order lets the
  // highest-numbered enabled port overwrite earlier matches.
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wr_idx[k*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[k*XLEN +: XLEN];
        end
      end
    end
    wr_hit[0] = 1'b0;
  end

  // Combinational reads; index 0 is forced to zero/not-busy last so that no
  // bypass path can leak a value into it.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = regs[rd_idx[p*AW +: AW]];
      rd_busy[p]              = busy[rd_idx[p*AW +: AW]];
      if ((BYPASS != 0) && wr_hit[rd_idx[p*AW +: AW]]) begin
        rd_data[p*XLEN +: XLEN] = wr_val[rd_idx[p*AW +: AW]];
        rd_busy[p]              = 1'b0;
      end
      if (rd_idx[p*AW +: AW] == '0) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
        // Flush wins over issue; a fresh issue wins over a writeback clear.
        if (flush) begin
          busy[r] <= 1'b0;
        end else if (iss_en && (iss_idx == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - scoreboard testbench for regfile_mp_sb
module tb_regfile_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*AW-1:0]   rd_idx;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_idx;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_idx;
  logic                flush;

  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .iss_en(iss_en),
    .iss_idx(iss_idx), .flush(flush), .busy_vec(busy_vec_b));

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .iss_en(iss_en),
    .iss_idx(iss_idx), .flush(flush), .busy_vec(busy_vec_n));

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_cmp(input string tag, input logic [63:0] got);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got=%h exp=none", tag, got);
    end else begin
      check(tag, got, sb_q.pop_front());
    end
  endtask

  function automatic logic [31:0] rdb(input int p);
    return rd_data_b[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] rdn(input int p);
    return rd_data_n[p*XLEN +: XLEN];
  endfunction

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_idx = '0; wr_data = '0;
    iss_en = 1'b0; iss_idx = '0; flush = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] idx, input logic [31:0] d);
    wr_en[k] = 1'b1;
    wr_idx[k*AW +: AW] = idx;
    wr_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] idx);
    rd_idx[p*AW +: AW] = idx;
  endtask

  task automatic iss(input logic [AW-1:0] idx);
    iss_en = 1'b1;
    iss_idx = idx;
  endtask

  // Advance one clock and return to a quiet input state just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Reference model for the randomised phase.
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_busy;

  task automatic rand_cycle();
    logic [AW-1:0] ix;
    logic [31:0]   eb, en;
    logic          bb, bn, hit;
    wr_en   = NWR'($urandom_range(0, 3));
    for (int k = 0; k < NWR; k++) begin
      wr_idx[k*AW +: AW]      = AW'($urandom_range(0, 7));
      wr_data[k*XLEN +: XLEN] = $urandom;
    end
    iss_en  = ($urandom_range(0, 1) == 1);
    iss_idx = AW'($urandom_range(0, 7));
    flush   = ($urandom_range(0, 15) == 0);
    for (int p = 0; p < NRD; p++) rd_idx[p*AW +: AW] = AW'($urandom_range(0, 7));
    #1;
    for (int p = 0; p < NRD; p++) begin
      ix = rd_idx[p*AW +: AW];
      en = m_regs[ix];
      bn = m_busy[ix];
      eb = en;
      hit = 1'b0;
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_idx[k*AW +: AW] == ix) begin
          eb = wr_data[k*XLEN +: XLEN];
          hit = 1'b1;
        end
      bb = hit ? 1'b0 : bn;
      if (ix == 0) begin eb = 0; en = 0; bb = 0; bn = 0; end
      sb_push({32'h0, eb});
      sb_push({32'h0, en});
      sb_push({63'h0, bb});
      sb_push({63'h0, bn});
      sb_cmp("rnd_rd_b", {32'h0, rdb(p)});
      sb_cmp("rnd_rd_n", {32'h0, rdn(p)});
      sb_cmp("rnd_busy_b", {63'h0, rd_busy_b[p]});
      sb_cmp("rnd_busy_n", {63'h0, rd_busy_n[p]});
    end
    sb_push({32'h0, m_busy});
    sb_push({32'h0, m_busy});
    sb_cmp("rnd_bvec_b", {32'h0, busy_vec_b});
    sb_cmp("rnd_bvec_n", {32'h0, busy_vec_n});
    for (int r = 1; r < NREGS; r++) begin
      hit = 1'b0;
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_idx[k*AW +: AW] == AW'(r)) begin
          m_regs[r] = wr_data[k*XLEN +: XLEN];
          hit = 1'b1;
        end
      if (flush) m_busy[r] = 1'b0;
      else if (iss_en && iss_idx == AW'(r)) m_busy[r] = 1'b1;
      else if (hit) m_busy[r] = 1'b0;
    end
    tick();
  endtask

  initial begin
    idle();
    rd_idx = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    idle();

    // Reset state
    rd(0, 5); rd(1, 0); #1;
    sb_push(0); sb_cmp("rst_rd5", {32'h0, rdb(0)});
    sb_push(0); sb_cmp("rst_rd0", {32'h0, rdb(1)});
    sb_push(0); sb_cmp("rst_busyrd", {62'h0, rd_busy_b});
    sb_push(0); sb_cmp("rst_bvec", {32'h0, busy_vec_b});

    // Preload x5 and mark busy, then reset (with competing write/issue)
    wr(0, 5, 32'hDEADBEEF); iss(5); tick();
    rd(0, 5); #1;
    sb_push(32'hDEADBEEF); sb_cmp("pre_x5", {32'h0, rdn(0)});
    sb_push(32'h20);       sb_cmp("pre_bvec", {32'h0, busy_vec_b});
    rst = 1'b1; wr(1, 6, 32'h1); iss(6); tick();
    rd(1, 6); #1;
    sb_push(0); sb_cmp("rstflush_x5", {32'h0, rdb(0)});
    sb_push(0); sb_cmp("rstflush_x6", {32'h0, rdb(1)});
    sb_push(0); sb_cmp("rstflush_bvec", {32'h0, busy_vec_b});

    // x0 immunity
    wr(0, 0, 32'hFFFFFFFF); iss(0); rd(0, 0); #1;
    sb_push(0); sb_cmp("x0_bypass", {32'h0, rdb(0)});
    sb_push(0); sb_cmp("x0_rdbusy", {63'h0, rd_busy_b[0]});
    tick(); #1;
    sb_push(0); sb_cmp("x0_rd", {32'h0, rdb(0)});
    sb_push(0); sb_cmp("x0_bvec", {32'h0, busy_vec_b});

    // Write collision: port 1 wins
    wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); rd(1, 7); #1;
    sb_push(32'h22222222); sb_cmp("coll_bypass", {32'h0, rdb(1)});
    sb_push(0);            sb_cmp("coll_nobypass", {32'h0, rdn(1)});
    tick(); #1;
    sb_push(32'h22222222); sb_cmp("coll_b", {32'h0, rdb(1)});
    sb_push(32'h22222222); sb_cmp("coll_n", {32'h0, rdn(1)});

    // Bypass modes
    wr(1, 3, 32'hA); tick();
    wr(0, 3, 32'hB); rd(0, 3); #1;
    sb_push(32'hB); sb_cmp("byp_on", {32'h0, rdb(0)});
    sb_push(32'hA); sb_cmp("byp_off", {32'h0, rdn(0)});
    tick(); #1;
    sb_push(32'hB); sb_cmp("byp_off_next", {32'h0, rdn(0)});

    // Scoreboard lifecycle
    iss(9); tick();
    rd(0, 9); #1;
    sb_push(32'h200); sb_cmp("sb_iss_bvec", {32'h0, busy_vec_b});
    sb_push(1);       sb_cmp("sb_iss_rdbusy", {63'h0, rd_busy_b[0]});
    wr(1, 9, 32'h99); #1;
    sb_push(0); sb_cmp("sb_wb_rdbusy_b", {63'h0, rd_busy_b[0]});
    sb_push(1); sb_cmp("sb_wb_rdbusy_n", {63'h0, rd_busy_n[0]});
    tick(); #1;
    sb_push(0); sb_cmp("sb_wb_bvec", {32'h0, busy_vec_b});
    wr(0, 9, 32'h98); iss(9); tick(); #1;
    sb_push(32'h200); sb_cmp("sb_wbiss_bvec", {32'h0, busy_vec_n});

    // Flush priority
    iss(4); tick();
    iss(12); tick(); #1;
    sb_push(32'h1210); sb_cmp("fl_pre_bvec", {32'h0, busy_vec_b});
    flush = 1'b1; iss(6); wr(0, 4, 32'h55); tick();
    rd(0, 4); #1;
    sb_push(0);     sb_cmp("fl_bvec_b", {32'h0, busy_vec_b});
    sb_push(0);     sb_cmp("fl_bvec_n", {32'h0, busy_vec_n});
    sb_push(32'h55); sb_cmp("fl_x4", {32'h0, rdn(0)});

    // Randomised phase against the reference model
    rst = 1'b1; tick();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int i = 0; i < 400; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard, the successor to the single-write-port CPU register file. It provides NRD combinational read ports and NWR write ports with fixed port priority, plus optional write-to-read bypass. It also tracks pending writebacks per register, so the issue stage can detect RAW hazards without a separate scoreboard. It sits between decode/issue (reads, issue marking) and writeback (writes, busy clear).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2); register 0 is hardwired zero
NRD, 2, number of read ports
NWR, 2, number of write ports; higher port index has higher priority
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-write contents
(localparam AW = $clog2(NREGS))

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_idx  in  NRD*AW  read indices, port p at [p*AW +: AW]
rd_data  out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
rd_busy  out  NRD  pending-write flag per read port
wr_en  in  NWR  write enable per write port
wr_idx  in  NWR*AW  write indices
wr_data  in  NWR*XLEN  write data
iss_en  in  1  mark iss_idx busy (instruction issued with destination iss_idx)
iss_idx  in  AW  destination being issued
flush  in  1  clear all busy bits (pipeline squash); data untouched
busy_vec  out  NREGS  current busy bits, bit r = register r

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: on a rising edge with rst=1, all registers become 0 and all busy bits become 0. rst overrides wr_en, iss_en and flush in the same cycle. Reset mid-operation discards pending writes and issues.
- After reset, every rd_data equals 0, every rd_busy equals 0, and busy_vec equals 0.
- Register 0 handling:
  - Writes to index 0 are ignored.
  - Reads of index 0 return 0, including under bypass.
  - iss_en with iss_idx=0 is ignored; busy bit 0 is constantly 0.
- Writes:
  - On a rising edge, for each index, the highest-numbered port p with wr_en[p]=1 and wr_idx[p]=index writes wr_data[p]. Lower-priority colliding writes are dropped.
  - Writes to distinct indices commit in parallel.
- Reads are combinational, with zero latency.
  - BYPASS=1: if any enabled write port targets rd_idx[p] (nonzero), rd_data[p] is the winning port's wr_data. Otherwise it is the stored value.
  - BYPASS=0: rd_data[p] is always the stored value; the new value is visible the cycle after the write.
- Busy scoreboard, next-state per register r != 0, evaluated in this order:
  - rst -> 0.
  - else flush -> 0. flush beats a same-cycle iss_en, and any same-cycle write still commits data.
  - else iss_en && iss_idx==r -> 1. A new issue beats a same-cycle writeback clear to the same register.
  - else any wr_en[k] && wr_idx[k]==r -> 0.
  - else hold.
- rd_busy[p] = busy[rd_idx[p]], except with BYPASS=1 it is forced to 0 when an enabled write targets rd_idx[p] this cycle. rd_busy for index 0 is always 0.
- busy_vec reflects registered state only; it is not bypassed.
- Width rules:
  - Indices are exactly AW bits, so no out-of-range accesses are possible.
  - Data is not sign-extended or truncated.
- No handshakes and no stalls; the block always accepts inputs.

Test Plan:
- Reset flush: preload x5=0xDEADBEEF and busy x5; assert rst for 1 cycle -> rd_data(x5)=0, busy_vec=0.
- x0 immunity: wr_en[0]=1, idx 0, data 0xFFFFFFFF; iss_en on idx 0 -> rd_data(x0)=0, busy_vec[0]=0, rd_busy=0.
- Write collision: port0 writes x7=0x11111111 and port1 writes x7=0x22222222 in the same cycle -> next cycle x7=0x22222222. Also, same-cycle read with BYPASS=1 returns 0x22222222.
- Bypass modes: with x3 holding 0xA, write x3=0xB and read x3 in the same cycle -> BYPASS=1 gives 0xB; BYPASS=0 gives 0xA, then 0xB the next cycle.
- Scoreboard lifecycle:
  - iss x9 -> busy_vec[9]=1 and rd_busy=1 next cycle.
  - Write x9 -> same cycle rd_busy=0 (BYPASS=1), busy_vec[9]=0 next cycle.
  - Write x9 plus iss x9 in the same cycle -> busy_vec[9]=1.
- Flush priority: busy x4 and x12; flush with iss_en x6 and a write x4=0x55 -> busy_vec=0 next cycle, x4=0x55.
